quad_decoder: RTL and testbench
===============================

QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter ERR_WIDTH, default 4, width of the illegal-transition error counter.
REQ-002 clk  input  1  single clock; all flops rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 enc_a  input  1  quadrature phase A, asynchronous to clk.
REQ-005 enc_b  input  1  quadrature phase B, asynchronous to clk.
REQ-006 enable  input  1  decode enable, synchronous.
REQ-007 clr_err  input  1  synchronous clear of err_count.
REQ-008 ce  output  1  one-cycle step strobe; connects to the counter's ce.
REQ-009 up_down  output  1  step direction, 1=up, 0=down; connects to the counter's up_down.
REQ-010 err  output  1  one-cycle strobe on an illegal (double-bit) phase transition.
REQ-011 err_count  output  ERR_WIDTH  saturating count of illegal transitions.

Function
REQ-012 Inputs pass through the input stage (REQ-030/031) to give a_s, b_s; prev_ab holds the last decoded {a_s,b_s}.
REQ-013 FSM states: INIT, TRACK.
REQ-014 INIT: on the first clock edge after reset release, load prev_ab <= {a_s,b_s}, go to TRACK, no strobes.
REQ-015 TRACK, enable=1: compare cur={a_s,b_s} with prev_ab each cycle, update prev_ab <= cur.
REQ-016 Forward sequence is 00->01->11->10->00; a forward step registers ce=1, up_down=1 for exactly one cycle.
REQ-017 Reverse sequence 00->10->11->01->00 registers ce=1, up_down=0 for exactly one cycle.
REQ-018 cur==prev_ab: ce=0; up_down holds its last value.
REQ-019 Both bits changed (00<->11, 01<->10): ce=0, err=1 for one cycle, err_count increments.
REQ-020 err_count saturates at all-ones ({ERR_WIDTH{1'b1}}); no wrap-around.
REQ-021 clr_err=1 sets err_count to 0 on the next edge; simultaneous clr_err and illegal transition: err pulses, err_count ends at 0 (clear wins).
REQ-022 TRACK, enable=0: prev_ab still tracks cur; ce=0, err=0, err_count unchanged; FSM stays in TRACK.
REQ-023 A step occurring during the cycle enable rises is decoded normally (no extra strobe from history).
REQ-024 ce, up_down, err are registered outputs; ce and err never assert in the same cycle.
REQ-025 Back-to-back steps on consecutive sampled cycles produce consecutive ce pulses, one per step.

Reset
REQ-026 rst_n=0 asynchronously forces: state=INIT, prev_ab=00, input-stage flops=0, ce=0, up_down=0, err=0, err_count=0.
REQ-027 Reset assertion mid-operation discards any pending step; no strobe is produced for it.
REQ-028 After reset release, a static input of 11 produces no err (INIT captures it).
REQ-029 Reset release is synchronous to clk; the first decode occurs no earlier than the second edge after release.

Configuration
REQ-030 QDEC_SYNC_EN defined: two-flop synchronizer per phase; input change -> ce high after the 3rd rising edge, for one cycle.
REQ-031 QDEC_SYNC_EN undefined: single register per phase; input change -> ce high after the 2nd rising edge, for one cycle; all other behaviour identical.

Verification
REQ-032 Reset, release with {enc_a,enc_b}=11, hold 10 cycles -> ce=0, err=0, err_count=0.
REQ-033 From 00, drive 01,11,10,00 each held 4 cycles -> 4 ce pulses with up_down=1; with the counter attached, count_out goes 0->4.
REQ-034 From 00, drive 10,11,01,00 -> 4 ce pulses with up_down=0; attached counter goes 0->15->14->13->12 (wrap at zero).
REQ-035 ERR_WIDTH=4, 20 alternating 00<->11 jumps -> 20 err pulses, no ce, err_count stops at 15; then clr_err=1 for one cycle -> err_count=0.
REQ-036 enable=0 while driving one full forward cycle, then enable=1 with inputs static -> no ce, no err.
REQ-037 Single 00->01 change, run with and without QDEC_SYNC_EN -> ce high after edge 3 and edge 2 respectively, width 1 cycle; rst_n pulsed low after edge 1 -> no ce.

Source files
------------

// File: rtl/quad_decoder.sv
// Quadrature decoder: turns phase A/B edges into ce/up_down step strobes and counts illegal jumps.
// Define QDEC_SYNC_EN to use a two-flop synchronizer per phase instead of a single input register.
module quad_decoder #(
    parameter int ERR_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enc_a,
    input  logic                 enc_b,
    input  logic                 enable,
    input  logic                 clr_err,
    output logic                 ce,
    output logic                 up_down,
    output logic                 err,
    output logic [ERR_WIDTH-1:0] err_count
);

    typedef enum logic {INIT, TRACK} state_t;

    state_t               state, state_next;
    logic                 a_s, b_s;
    logic [1:0]           cur;
    logic [1:0]           prev_ab, prev_next;
    logic                 ce_next, up_next, err_next;
    logic [ERR_WIDTH-1:0] cnt_next;

`ifdef QDEC_SYNC_EN
    logic a_meta, b_meta;

    // INIT seeds the whole input stage from the pins so a static input is not seen as a jump.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_meta <= 1'b0;
            b_meta <= 1'b0;
            a_s    <= 1'b0;
            b_s    <= 1'b0;
        end else begin
            a_meta <= enc_a;
            b_meta <= enc_b;
            if (state == INIT) begin
                a_s <= enc_a;
                b_s <= enc_b;
            end else begin
                a_s <= a_meta;
                b_s <= b_meta;
            end
        end
    end
`else
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_s <= 1'b0;
            b_s <= 1'b0;
        end else begin
            a_s <= enc_a;
            b_s <= enc_b;
        end
    end
`endif

    assign cur = {a_s, b_s};

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        prev_next  = prev_ab;
        ce_next    = 1'b0;
        err_next   = 1'b0;
        up_next    = up_down;
        cnt_next   = err_count;
        case (state)
            INIT: begin
                prev_next  = {enc_a, enc_b};
                state_next = TRACK;
            end
            TRACK: begin
                prev_next = cur;
                if (enable) begin
                    case (cur ^ prev_ab)
                        2'b00: ;
                        2'b11: begin
                            err_next = 1'b1;
                            if (err_count != {ERR_WIDTH{1'b1}})
                                cnt_next = err_count + 1'b1;
                        end
                        // One bit changed: forward when old A differs from new B (Gray order 00,01,11,10).
                        default: begin
                            ce_next = 1'b1;
                            up_next = prev_ab[1] ^ cur[0];
                        end
                    endcase
                end
            end
            default: state_next = INIT;
        endcase
        if (clr_err)
            cnt_next = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            prev_ab   <= 2'b00;
            ce        <= 1'b0;
            up_down   <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_next;
            prev_ab   <= prev_next;
            ce        <= ce_next;
            up_down   <= up_next;
            err       <= err_next;
            err_count <= cnt_next;
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: directed scenarios plus a random walk against a
// position-based reference model. Compile with QDEC_SYNC_EN to check the synchronized build.
module tb_quad_decoder;

    localparam int W    = 4;
`ifdef QDEC_SYNC_EN
    localparam int L    = 2;
`else
    localparam int L    = 1;
`endif
    localparam logic [W-1:0] MAXC = 4'd15;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enc_a = 1'b0, enc_b = 1'b0, enable = 1'b1, clr_err = 1'b0;
    logic         ce, up_down, err;
    logic [W-1:0] err_count;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [1:0]   hist[$];
    int           k;
    logic         m_ce, m_up, m_err;
    logic [W-1:0] m_cnt;

    quad_decoder #(.ERR_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b),
        .enable(enable), .clr_err(clr_err),
        .ce(ce), .up_down(up_down), .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic int pos_of(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] ab_of(input int p);
        case (p % 4)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    function automatic int clampi(input int i);
        return (i < 1) ? 1 : i;
    endfunction

    // Drive one sampled cycle, advance one edge, update the model, then settle 1 time unit.
    task automatic tick(input logic [1:0] ab, input logic en, input logic clr);
        logic [1:0] c, p;
        int d;
        enc_a = ab[1]; enc_b = ab[0]; enable = en; clr_err = clr;
        @(posedge clk);
        hist.push_back(ab);
        k++;
        m_ce  = 1'b0;
        m_err = 1'b0;
        if (k > 1 && en) begin
            c = hist[clampi(k - L) - 1];
            p = hist[clampi(k - L - 1) - 1];
            d = (pos_of(c) - pos_of(p) + 4) % 4;
            if (d == 1) begin
                m_ce = 1'b1; m_up = 1'b1;
            end else if (d == 3) begin
                m_ce = 1'b1; m_up = 1'b0;
            end else if (d == 2) begin
                m_err = 1'b1;
                if (m_cnt != MAXC) m_cnt = m_cnt + 1'b1;
            end
        end
        if (clr) m_cnt = '0;
        #1;
    endtask

    task automatic do_reset(input logic [1:0] ab);
        enc_a = ab[1]; enc_b = ab[0]; enable = 1'b1; clr_err = 1'b0;
        rst_n = 1'b0;
        #1;
        hist.delete();
        k = 0; m_ce = 0; m_up = 0; m_err = 0; m_cnt = '0;
        total++;
        if ({ce, up_down, err, err_count} !== 7'd0) begin
            bad++;
            $display("FAIL reset_async got=%b want=0000000", {ce, up_down, err, err_count});
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(2'b11);
        for (int i = 0; i < 10; i++) begin
            tick(2'b11, 1'b1, 1'b0);
            total++;
            if ({ce, err, err_count} !== 6'd0 || {ce, up_down, err, err_count} !== {m_ce, m_up, m_err, m_cnt}) begin
                bad++;
                $display("FAIL reset_static11 cyc=%0d got=%b want=%b", i, {ce, up_down, err, err_count}, {m_ce, m_up, m_err, m_cnt});
            end
        end
    endtask

    task automatic test_direction(input bit fwd);
        logic [1:0] seq[4];
        logic [3:0] cnt4 = 4'd0;
        int pulses = 0;
        if (fwd) seq = '{2'b01, 2'b11, 2'b10, 2'b00};
        else     seq = '{2'b10, 2'b11, 2'b01, 2'b00};
        do_reset(2'b00);
        repeat (3) tick(2'b00, 1'b1, 1'b0);
        for (int s = 0; s < 7; s++) begin
            for (int h = 0; h < 4; h++) begin
                tick((s < 4) ? seq[s] : 2'b00, 1'b1, 1'b0);
                if (ce) begin
                    pulses++;
                    cnt4 = up_down ? cnt4 + 4'd1 : cnt4 - 4'd1;
                end
                total++;
                if ({ce, up_down, err, err_count} !== {m_ce, m_up, m_err, m_cnt}) begin
                    bad++;
                    $display("FAIL dir%0d s=%0d h=%0d got=%b want=%b", fwd, s, h, {ce, up_down, err, err_count}, {m_ce, m_up, m_err, m_cnt});
                end
            end
        end
        total++;
        if (pulses != 4 || cnt4 !== (fwd ? 4'd4 : 4'd12)) begin
            bad++;
            $display("FAIL dir%0d_counter pulses=%0d count=%0d want pulses=4 count=%0d", fwd, pulses, cnt4, fwd ? 4 : 12);
        end
    endtask

    task automatic test_errors();
        int errs = 0, ces = 0;
        do_reset(2'b00);
        repeat (3) tick(2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 43; i++) begin
            tick((i < 40 && (i / 2) % 2 == 0) ? 2'b11 : 2'b00, 1'b1, 1'b0);
            errs += int'(err);
            ces  += int'(ce);
            total++;
            if ({ce, up_down, err, err_count} !== {m_ce, m_up, m_err, m_cnt}) begin
                bad++;
                $display("FAIL err_seq i=%0d got=%b want=%b", i, {ce, up_down, err, err_count}, {m_ce, m_up, m_err, m_cnt});
            end
        end
        total++;
        if (errs != 20 || ces != 0 || err_count !== 4'd15) begin
            bad++;
            $display("FAIL err_saturate errs=%0d ces=%0d cnt=%0d want 20/0/15", errs, ces, err_count);
        end
        tick(2'b00, 1'b1, 1'b1);
        total++;
        if (err_count !== 4'd0) begin
            bad++;
            $display("FAIL err_clear cnt=%0d want=0", err_count);
        end
        // Clear coincides with the edge that registers a new illegal jump.
        tick(2'b11, 1'b1, 1'b0);
        for (int j = 2; j <= L + 1; j++) tick(2'b11, 1'b1, (j == L + 1));
        total++;
        if (err !== 1'b1 || err_count !== 4'd0 || m_err !== 1'b1) begin
            bad++;
            $display("FAIL clr_wins err=%b cnt=%0d want err=1 cnt=0", err, err_count);
        end
        clr_err = 1'b0;
    endtask

    task automatic test_enable();
        logic [1:0] seq[4] = '{2'b01, 2'b11, 2'b10, 2'b00};
        do_reset(2'b00);
        repeat (3) tick(2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            tick((i < 8) ? seq[i / 2] : 2'b00, (i >= 8), 1'b0);
            total++;
            if ({ce, err} !== 2'b00 || {ce, up_down, err, err_count} !== {m_ce, m_up, m_err, m_cnt}) begin
                bad++;
                $display("FAIL enable_gate i=%0d got=%b want ce=0 err=0", i, {ce, up_down, err, err_count});
            end
        end
    endtask

    task automatic test_latency();
        logic [4:0] seen = '0;
        logic [4:0] want;
        want = 5'b00001 << L;
        do_reset(2'b00);
        repeat (4) tick(2'b00, 1'b1, 1'b0);
        for (int j = 0; j < 5; j++) begin
            tick(2'b01, 1'b1, 1'b0);
            seen[j] = ce;
        end
        total++;
        if (seen !== want) begin
            bad++;
            $display("FAIL latency ce_by_edge=%b want=%b", seen, want);
        end
        // Reset after the first edge must drop the pending step.
        do_reset(2'b00);
        repeat (4) tick(2'b00, 1'b1, 1'b0);
        tick(2'b01, 1'b1, 1'b0);
        do_reset(2'b01);
        for (int j = 0; j < 6; j++) begin
            tick(2'b01, 1'b1, 1'b0);
            total++;
            if ({ce, err} !== 2'b00 || {ce, up_down, err, err_count} !== {m_ce, m_up, m_err, m_cnt}) begin
                bad++;
                $display("FAIL reset_drop j=%0d got=%b want ce=0 err=0", j, {ce, up_down, err, err_count});
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        do_reset(2'b00);
        repeat (3) tick(2'b00, 1'b1, 1'b0);
        for (int i = 1; i <= 11; i++) begin
            tick(ab_of((i <= 8) ? i : 8), 1'b1, 1'b0);
            pulses += int'(ce);
            total++;
            if ({ce, up_down, err, err_count} !== {m_ce, m_up, m_err, m_cnt}) begin
                bad++;
                $display("FAIL b2b i=%0d got=%b want=%b", i, {ce, up_down, err, err_count}, {m_ce, m_up, m_err, m_cnt});
            end
        end
        total++;
        if (pulses != 8) begin
            bad++;
            $display("FAIL b2b_count pulses=%0d want=8", pulses);
        end
    endtask

    task automatic test_random();
        int p = 0;
        int r;
        do_reset(2'b00);
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 9);
            if (r >= 3 && r <= 5) p = p + 1;
            else if (r >= 6 && r <= 8) p = p + 3;
            else if (r == 9) p = p + 2;
            tick(ab_of(p), ($urandom_range(0, 7) != 0), ($urandom_range(0, 31) == 0));
            total++;
            if ({ce, up_down, err, err_count} !== {m_ce, m_up, m_err, m_cnt}) begin
                bad++;
                $display("FAIL random i=%0d got=%b want=%b", i, {ce, up_down, err, err_count}, {m_ce, m_up, m_err, m_cnt});
            end
            total++;
            if (ce && err) begin
                bad++;
                $display("FAIL ce_err_excl i=%0d got ce=1 err=1 want not both", i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_direction(1'b1);
        test_direction(1'b0);
        test_errors();
        test_enable();
        test_latency();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
